// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: IEEE 1149.1 TAP controller with IR, BYPASS, IDCODE and one user DR.
// Rev 1.0 - initial release.
`default_nettype none

module jtag_tap_ctrl #(
  parameter int          IR_WIDTH      = 4,
  parameter logic [31:0] IDCODE_VALUE  = 32'h1000_0001,
  parameter int          IDCODE_OP     = 1,
  parameter int          USER_OP       = 2,
  parameter int          USER_DR_WIDTH = 8
) (
  input  logic                     TCK,
  input  logic                     TRST,
  input  logic                     TMS,
  input  logic                     TDI,
  output logic                     TDO,
  output logic                     TDO_en,
  output logic [IR_WIDTH-1:0]      ir_value,
  input  logic [USER_DR_WIDTH-1:0] user_capture_data,
  output logic [USER_DR_WIDTH-1:0] user_update_data,
  output logic                     user_update,
  output logic [3:0]               tap_state
);

  localparam logic [3:0] TLR  = 4'd0;
  localparam logic [3:0] RTI  = 4'd1;
  localparam logic [3:0] SDRS = 4'd2;
  localparam logic [3:0] SIRS = 4'd3;
  localparam logic [3:0] CDR  = 4'd4;
  localparam logic [3:0] CIR  = 4'd5;
  localparam logic [3:0] SDR  = 4'd6;
  localparam logic [3:0] SIR  = 4'd7;
  localparam logic [3:0] E1DR = 4'd8;
  localparam logic [3:0] E1IR = 4'd9;
  localparam logic [3:0] PDR  = 4'd10;
  localparam logic [3:0] PIR  = 4'd11;
  localparam logic [3:0] E2DR = 4'd12;
  localparam logic [3:0] E2IR = 4'd13;
  localparam logic [3:0] UDR  = 4'd14;
  localparam logic [3:0] UIR  = 4'd15;

  localparam logic [IR_WIDTH-1:0] IDCODE_CODE = IR_WIDTH'(IDCODE_OP);
  localparam logic [IR_WIDTH-1:0] USER_CODE   = IR_WIDTH'(USER_OP);
  localparam logic [IR_WIDTH-1:0] IR_CAPTURE  = IR_WIDTH'(2'b01);

  generate
    if (IDCODE_VALUE[0] != 1'b1) begin : g_idcode_lsb_check
      $error("jtag_tap_ctrl: IDCODE_VALUE bit 0 must be 1");
    end
    if (IR_WIDTH < 2) begin : g_ir_width_check
      $error("jtag_tap_ctrl: IR_WIDTH must be at least 2");
    end
    if (USER_DR_WIDTH < 1) begin : g_user_width_check
      $error("jtag_tap_ctrl: USER_DR_WIDTH must be at least 1");
    end
  endgenerate

  logic [3:0]               state;
  logic [3:0]               next_state;
  logic [IR_WIDTH-1:0]      ir_shift;
  logic                     bypass_reg;
  logic [31:0]              idcode_shift;
  logic [USER_DR_WIDTH-1:0] user_shift;
  logic                     sel_idcode;
  logic                     sel_user;
  logic                     dr_lsb;
  logic                     tdo_next;

  // Instruction decode; anything not IDCODE or USER falls through to BYPASS.
  assign sel_idcode = (ir_value == IDCODE_CODE);
  assign sel_user   = (ir_value == USER_CODE) && !sel_idcode;

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) state <= TLR;
    else      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      TLR:  next_state = TMS ? TLR  : RTI;
      RTI:  next_state = TMS ? SDRS : RTI;
      SDRS: next_state = TMS ? SIRS : CDR;
      SIRS: next_state = TMS ? TLR  : CIR;
      CDR:  next_state = TMS ? E1DR : SDR;
      SDR:  next_state = TMS ? E1DR : SDR;
      E1DR: next_state = TMS ? UDR  : PDR;
      PDR:  next_state = TMS ? E2DR : PDR;
      E2DR: next_state = TMS ? UDR  : SDR;
      CIR:  next_state = TMS ? E1IR : SIR;
      SIR:  next_state = TMS ? E1IR : SIR;
      E1IR: next_state = TMS ? UIR  : PIR;
      PIR:  next_state = TMS ? E2IR : PIR;
      E2IR: next_state = TMS ? UIR  : SIR;
      UDR:  next_state = TMS ? SDRS : RTI;
      UIR:  next_state = TMS ? SDRS : RTI;
      default: next_state = TLR;
    endcase
  end

  always_comb begin
    tap_state   = state;
    user_update = (state == UDR) && sel_user;
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      ir_shift <= '0;
      ir_value <= IDCODE_CODE;
    end else begin
      case (state)
        CIR:     ir_shift <= IR_CAPTURE;
        SIR:     ir_shift <= {TDI, ir_shift[IR_WIDTH-1:1]};
        default: ir_shift <= ir_shift;
      endcase
      if (next_state == TLR)  ir_value <= IDCODE_CODE;
      else if (state == UIR)  ir_value <= ir_shift;
    end
  end

  always_ff @(posedge TCK or posedge TRST) begin
    if (TRST) begin
      bypass_reg       <= 1'b0;
      idcode_shift     <= '0;
      user_shift       <= '0;
      user_update_data <= '0;
    end else begin
      if (state == CDR) begin
        if (sel_idcode)    idcode_shift <= IDCODE_VALUE;
        else if (sel_user) user_shift   <= user_capture_data;
        else               bypass_reg   <= 1'b0;
      end else if (state == SDR) begin
        if (sel_idcode)    idcode_shift <= {TDI, idcode_shift[31:1]};
        else if (sel_user) user_shift   <= {TDI, user_shift[USER_DR_WIDTH-1:1]};
        else               bypass_reg   <= TDI;
      end
      if ((state == UDR) && sel_user) user_update_data <= user_shift;
    end
  end

  always_comb begin
    if (sel_idcode)    dr_lsb = idcode_shift[0];
    else if (sel_user) dr_lsb = user_shift[0];
    else               dr_lsb = bypass_reg;
    case (state)
      SIR:     tdo_next = ir_shift[0];
      SDR:     tdo_next = dr_lsb;
      default: tdo_next = 1'b0;
    endcase
  end

  // TDO changes on the falling edge so the far end can sample it on the next rising edge.
  always_ff @(negedge TCK or posedge TRST) begin
    if (TRST) begin
      TDO    <= 1'b0;
      TDO_en <= 1'b0;
    end else begin
      TDO    <= tdo_next;
      TDO_en <= (state == SIR) || (state == SDR);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_jtag_tap_ctrl.sv
// tb_jtag_tap_ctrl: directed scans with a TDO scoreboard for jtag_tap_ctrl.
// Rev 1.0 - initial release.
`default_nettype none

module tb_jtag_tap_ctrl;

  localparam int IR_W = 4;
  localparam int UW   = 8;

  logic            TCK = 1'b0;
  logic            TRST;
  logic            TMS;
  logic            TDI;
  logic            TDO;
  logic            TDO_en;
  logic [IR_W-1:0] ir_value;
  logic [UW-1:0]   user_capture_data;
  logic [UW-1:0]   user_update_data;
  logic            user_update;
  logic [3:0]      tap_state;

  jtag_tap_ctrl dut (
    .TCK               (TCK),
    .TRST              (TRST),
    .TMS               (TMS),
    .TDI               (TDI),
    .TDO               (TDO),
    .TDO_en            (TDO_en),
    .ir_value          (ir_value),
    .user_capture_data (user_capture_data),
    .user_update_data  (user_update_data),
    .user_update       (user_update),
    .tap_state         (tap_state)
  );

  always #5 TCK = ~TCK;

  logic exp_q[$];
  int   n_cmp      = 0;
  int   n_fail     = 0;
  int   en_count   = 0;
  int   upd_count  = 0;

  // Monitor: every enabled TDO bit seen at a rising edge is matched against the queue.
  always begin
    logic exp_bit;
    @(posedge TCK);
    #2;
    if (user_update === 1'b1) upd_count++;
    if (TDO_en === 1'b1) begin
      en_count++;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL tdo_unexpected: got %0b with no bit expected (t=%0t)", TDO, $time);
      end else begin
        exp_bit = exp_q.pop_front();
        if (TDO !== exp_bit) begin
          n_fail++;
          $display("FAIL tdo_bit: got %0b expected %0b (t=%0t)", TDO, exp_bit, $time);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic tms, input logic tdi);
    TMS = tms;
    TDI = tdi;
    @(posedge TCK);
    #1;
  endtask

  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(v[i]);
  endtask

  task automatic shift(input logic [31:0] bits, input int n);
    for (int i = 0; i < n; i++) tick(i == n - 1, bits[i]);
  endtask

  // From RTI: load an instruction and return to RTI.
  task automatic ir_scan(input logic [IR_W-1:0] op);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    push_bits(32'b0001, IR_W);
    shift(32'(op), IR_W);
    tick(1, 0); tick(0, 0);
  endtask

  // From RTI: capture, shift n bits, stop in Exit1-DR.
  task automatic dr_scan(input logic [31:0] tdi_bits, input logic [31:0] exp_bits, input int n);
    tick(1, 0); tick(0, 0); tick(0, 0);
    push_bits(exp_bits, n);
    shift(tdi_bits, n);
  endtask

  initial begin
    TRST = 1'b1; TMS = 1'b1; TDI = 1'b0;
    user_capture_data = 8'hA5;
    @(posedge TCK); #1;
    chk("reset_state", 32'(tap_state), 0);
    chk("reset_ir", 32'(ir_value), 1);
    chk("reset_tdo", 32'(TDO), 0);
    chk("reset_tdo_en", 32'(TDO_en), 0);
    chk("reset_user_data", 32'(user_update_data), 0);
    chk("reset_user_update", 32'(user_update), 0);
    #2 TRST = 1'b0;
    @(posedge TCK); #1;

    // IDCODE read: 32 bits LSB first.
    tick(0, 0);
    chk("rti_state", 32'(tap_state), 1);
    en_count = 0;
    tick(1, 0); tick(0, 0); tick(0, 0);
    push_bits(32'h1000_0001, 32);
    shift(32'h0, 32);
    chk("e1dr_state", 32'(tap_state), 8);
    tick(1, 0);
    chk("idcode_en_count", 32'(en_count), 32);
    tick(0, 0);

    // Five TMS=1 from Shift-DR.
    tick(1, 0); tick(0, 0); tick(0, 0);
    chk("sdr_state", 32'(tap_state), 6);
    push_bits(32'h1, 1);
    for (int i = 0; i < 5; i++) tick(1, 0);
    chk("tlr_from_sdr", 32'(tap_state), 0);
    chk("ir_after_tlr_sdr", 32'(ir_value), 1);

    // Five TMS=1 from Pause-IR.
    tick(0, 0); tick(1, 0); tick(1, 0); tick(0, 0); tick(1, 0); tick(0, 0);
    chk("pir_state", 32'(tap_state), 11);
    for (int i = 0; i < 5; i++) tick(1, 0);
    chk("tlr_from_pir", 32'(tap_state), 0);

    // IR scan of all-ones.
    tick(0, 0); tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    chk("sir_state", 32'(tap_state), 7);
    push_bits(32'b0001, 4);
    shift(32'hF, 4);
    chk("e1ir_state", 32'(tap_state), 9);
    chk("ir_before_update", 32'(ir_value), 1);
    tick(1, 0); tick(0, 0);
    chk("ir_all_ones", 32'(ir_value), 32'hF);

    // BYPASS: TDI 1,0,1,1 -> TDO 0,1,0,1.
    dr_scan(32'b1101, 32'b1010, 4);
    tick(1, 0);
    chk("udr_state", 32'(tap_state), 14);
    chk("bypass_no_update", 32'(user_update), 0);
    for (int i = 0; i < 5; i++) tick(1, 0);
    chk("tlr_from_udr", 32'(tap_state), 0);
    chk("ir_after_tlr_udr", 32'(ir_value), 1);

    // User DR: capture A5, shift in 3C.
    tick(0, 0);
    ir_scan(4'h2);
    chk("ir_user", 32'(ir_value), 2);
    dr_scan(32'h3C, 32'hA5, 8);
    chk("user_data_pre_update", 32'(user_update_data), 0);
    tick(1, 0);
    chk("user_udr_state", 32'(tap_state), 14);
    chk("user_update_high", 32'(user_update), 1);
    tick(0, 0);
    chk("user_update_low", 32'(user_update), 0);
    chk("user_update_data", 32'(user_update_data), 32'h3C);

    // Undefined opcode 7 behaves as BYPASS.
    chk("upd_count_one", 32'(upd_count), 1);
    ir_scan(4'h7);
    chk("ir_undef", 32'(ir_value), 7);
    dr_scan(32'b1011, 32'b0110, 4);
    tick(1, 0); tick(0, 0); tick(0, 0);
    chk("undef_upd_count", 32'(upd_count), 1);
    chk("undef_user_data_held", 32'(user_update_data), 32'h3C);

    // Asynchronous reset in the middle of a user DR shift.
    ir_scan(4'h2);
    user_capture_data = 8'h5A;
    tick(1, 0); tick(0, 0); tick(0, 0);
    push_bits(32'h5A, 3);
    for (int i = 0; i < 3; i++) tick(0, 1);
    #2 TRST = 1'b1;
    #1;
    chk("trst_state", 32'(tap_state), 0);
    chk("trst_tdo", 32'(TDO), 0);
    chk("trst_tdo_en", 32'(TDO_en), 0);
    chk("trst_user_data", 32'(user_update_data), 0);
    chk("trst_ir", 32'(ir_value), 1);
    @(negedge TCK);
    TRST = 1'b0;
    tick(1, 0); tick(1, 0);
    chk("queue_drained", 32'(exp_q.size()), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
